// File: rtl/cgra_bist_pkg.sv
// Shared types and helpers for the CGRA stream self-test harness.
// Galois step polynomial and width limits live here.
package cgra_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONF,
    RUN,
    DRAIN,
    DUMP
  } state_t;

  localparam logic [31:0] MISR_POLY = 32'h0040_0007;
  localparam int MAX_WIDTH = 32;
  localparam int DUMP_CYCLES = 32;

  function automatic logic [31:0] step(
    input logic [31:0] x
  );
    return {x[30:0], 1'b0} ^ (x[31] ? MISR_POLY : 32'h0);
  endfunction

  function automatic bit width_ok(input int w);
    return (w >= 1) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/cgra_bist_lfsr.sv
// 32-bit Galois register with load, enable and XOR inject.
// nxt exposes the value taken at the coming edge.
module cgra_bist_lfsr
  import cgra_bist_pkg::*;
#(
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        en,
  input  logic [31:0] inject,
  output logic [31:0] q,
  output logic [31:0] nxt
);

  always_comb begin
    nxt = q;
    if (load) nxt = seed;
    else if (en) nxt = step(q) ^ inject;
  end

  always_ff @(posedge clk) begin
    if (rst) q <= RST_VAL;
    else q <= nxt;
  end

endmodule

// File: rtl/cgra_stream_bist.sv
// Sequenced self-test harness around the CGRA mesh:
// config stream, stimulus, MISR compaction, serial dump.
module cgra_stream_bist
  import cgra_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CONF_WIDTH = 8,
  parameter int NUM_IN = 3,
  parameter int NUM_OUT = 3,
  parameter int CONF_CYCLES = 16,
  parameter int RUN_CYCLES = 256,
  parameter int DRAIN_CYCLES = 4,
  parameter int STIM_MODE = 0,
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic [CONF_WIDTH-1:0]         conf_bus,
  output logic [NUM_IN*DATA_WIDTH-1:0]  in_streams,
  input  logic [NUM_OUT*DATA_WIDTH-1:0] out_streams,
  output logic                          busy,
  output logic                          done,
  output logic                          out
);

  localparam int IW = NUM_IN * DATA_WIDTH;
  localparam logic [31:0] CONF_LAST = 32'(CONF_CYCLES - 1);
  localparam logic [31:0] RUN_LAST = 32'(RUN_CYCLES - 1);
  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
  localparam logic [31:0] DUMP_LAST = 32'(DUMP_CYCLES - 1);

  if (!width_ok(DATA_WIDTH) || !width_ok(CONF_WIDTH))
  begin : g_bad_width
    $error("DATA_WIDTH/CONF_WIDTH must be 1..32");
  end

  if (CONF_CYCLES < 1 || RUN_CYCLES < 1 || DRAIN_CYCLES < 0)
  begin : g_bad_cycles
    $error("CONF/RUN_CYCLES must be >= 1");
  end

  state_t      st, st_n;
  logic [31:0] cnt, cnt_n;
  logic        accept;

  assign accept = (st == IDLE) && start;

  always_comb begin
    st_n = st;
    cnt_n = cnt + 32'd1;
    unique case (st)
      IDLE: begin
        cnt_n = '0;
        if (start) st_n = CONF;
      end
      CONF: if (cnt == CONF_LAST) begin
        st_n = RUN;
        cnt_n = '0;
      end
      RUN: if (cnt == RUN_LAST) begin
        st_n = (DRAIN_CYCLES == 0) ? DUMP : DRAIN;
        cnt_n = '0;
      end
      DRAIN: if (cnt == DRAIN_LAST) begin
        st_n = DUMP;
        cnt_n = '0;
      end
      DUMP: if (cnt == DUMP_LAST) begin
        st_n = IDLE;
        cnt_n = '0;
      end
      default: begin
        st_n = IDLE;
        cnt_n = '0;
      end
    endcase
  end

  // Stimulus: one register per channel, stepped on each RUN cycle.
  logic [IW-1:0] stim_d;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    localparam logic [31:0] CH_SEED = SEED + 32'(i);
    logic [31:0] q;
    logic [31:0] nxt;
    logic [DATA_WIDTH-1:0] cnt_val;
    logic unused_bits;

    cgra_bist_lfsr #(
      .RST_VAL(CH_SEED)
    ) u_stim (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .seed  (CH_SEED),
      .en    (st_n == RUN),
      .inject(32'h0),
      .q     (q),
      .nxt   (nxt)
    );

    assign cnt_val = DATA_WIDTH'(32'(i) + cnt_n);
    assign unused_bits = ^{q, nxt};
    assign stim_d[i*DATA_WIDTH +: DATA_WIDTH] =
      (STIM_MODE != 0) ? q[DATA_WIDTH-1:0] : cnt_val;
  end

  logic [DATA_WIDTH-1:0] fold;

  always_comb begin
    fold = '0;
    for (int c = 0; c < NUM_OUT; c++)
      fold ^= out_streams[c*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [31:0] misr, misr_nxt;

  cgra_bist_lfsr #(
    .RST_VAL(32'h0)
  ) u_misr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .seed  (32'h0),
    .en    ((st == RUN) || (st == DRAIN)),
    .inject(32'(fold)),
    .q     (misr),
    .nxt   (misr_nxt)
  );

  // Outputs are registered from the next state so they line up with st.
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      conf_bus <= '0;
      in_streams <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      out <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      conf_bus <= (st_n == CONF) ?
        cnt_n[CONF_WIDTH-1:0] : '0;
      in_streams <= (st_n == RUN) ? stim_d : '0;
      busy <= (st_n != IDLE);
      out <= (st_n == DUMP) ?
        misr_nxt[~cnt_n[4:0]] : ^misr_nxt;
      if (accept) done <= 1'b0;
      else if (st == DUMP && st_n == IDLE) done <= 1'b1;
    end
  end

endmodule
